hazard_controller: RTL and testbench

- Central stall/flush/forward sequencer for the five-stage RV32i pipeline.
- Drives the enable (stall) and clear (flush) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the EX-stage operand forwarding selects.
- Resolves load-use hazards, taken branches/jumps and multi-cycle data-memory waits.
- Watchdogs memory accesses with a timeout state.

---
 rtl/hazard_controller.sv | 145 ++++++++++++++
 tb/tb_hazard_controller.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_controller: RV32i pipeline stall/flush/forward sequencer with       |
// | data-memory wait watchdog.   Revision: 1.0                                 |
// +----------------------------------------------------------------------------+
module hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [4:0]             RS1_D,
    input  logic [4:0]             RS2_D,
    input  logic [4:0]             RS1_E,
    input  logic [4:0]             RS2_E,
    input  logic [4:0]             RD_E,
    input  logic [1:0]             Result_Src_Sel_E,
    input  logic                   PC_Src_Sel_E,
    input  logic [4:0]             RD_M,
    input  logic                   REG_W_En_M,
    input  logic                   MEM_Req_M,
    input  logic                   MEM_Ack,
    input  logic [4:0]             RD_W,
    input  logic                   REG_W_En_W,
    output logic                   Stall_F,
    output logic                   Stall_D,
    output logic                   Stall_E,
    output logic                   Stall_M,
    output logic                   Flush_D,
    output logic                   Flush_E,
    output logic                   Flush_W,
    output logic [1:0]             Forward_A_E,
    output logic [1:0]             Forward_B_E,
    output logic                   MEM_Err,
    output logic [STALL_CNT_W-1:0] Stall_Cycles
);

    localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_TIMEOUT  = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_WAIT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
    logic                  w_mem_err_set;
    logic                  w_mem_stall;
    logic                  w_load_use;

    // MEM stage wins over WB so the youngest value is forwarded; x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (REG_W_En_M && (RD_M != 5'd0) && (RD_M == rs))
            return 2'b10;
        else if (REG_W_En_W && (RD_W != 5'd0) && (RD_W == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_mem_stall = (r_state != S_TIMEOUT) && MEM_Req_M && !MEM_Ack;
    assign w_load_use  = (Result_Src_Sel_E == 2'b01) && (RD_E != 5'd0) &&
                         ((RD_E == RS1_D) || (RD_E == RS2_D));

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_err_set  = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt    = S_MEM_WAIT;
                    w_wait_cnt_nxt = c_WAIT_W'(1);
                end
            end
            S_MEM_WAIT: begin
                if (MEM_Ack || !MEM_Req_M) begin
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == c_WAIT_MAX) begin
                    w_state_nxt   = S_TIMEOUT;
                    w_mem_err_set = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + c_WAIT_W'(1);
                end
            end
            default: w_state_nxt = S_TIMEOUT;
        endcase
    end

    always_comb begin
        Stall_F     = 1'b0;
        Stall_D     = 1'b0;
        Stall_E     = 1'b0;
        Stall_M     = 1'b0;
        Flush_D     = 1'b0;
        Flush_E     = 1'b0;
        Flush_W     = 1'b0;
        Forward_A_E = 2'b00;
        Forward_B_E = 2'b00;
        if (RST) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
            Flush_W = 1'b1;
        end else begin
            Forward_A_E = fwd_sel(RS1_E);
            Forward_B_E = fwd_sel(RS2_E);
            if ((r_state == S_TIMEOUT) || w_mem_stall) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Stall_E = 1'b1;
                Stall_M = 1'b1;
                Flush_W = 1'b1;
            end else if (PC_Src_Sel_E) begin
                // The load-use consumer sits in ID and is flushed, so no stall is needed.
                Flush_D = 1'b1;
                Flush_E = 1'b1;
            end else if (w_load_use) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Flush_E = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_RUN;
            r_wait_cnt   <= '0;
            MEM_Err      <= 1'b0;
            Stall_Cycles <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_mem_err_set)
                MEM_Err <= 1'b1;
            if (Stall_F && !(&Stall_Cycles))
                Stall_Cycles <= Stall_Cycles + STALL_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hazard_controller: scoreboard bench for hazard_controller.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hazard_controller;

    localparam int c_TO    = 4;
    localparam int c_CNT_W = 4;
    localparam int c_CNT_MAX = (1 << c_CNT_W) - 1;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
    logic [1:0] Result_Src_Sel_E;
    logic       PC_Src_Sel_E, REG_W_En_M, MEM_Req_M, MEM_Ack, REG_W_En_W;
    logic       Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, MEM_Err;
    logic [1:0] Forward_A_E, Forward_B_E;
    logic [c_CNT_W-1:0] Stall_Cycles;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    logic [11:0] sb[$];
    logic [11:0] w_obs;

    hazard_controller #(.MEM_TIMEOUT(c_TO), .STALL_CNT_W(c_CNT_W)) u_dut (
        .CLK(CLK), .RST(RST),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
        .Result_Src_Sel_E(Result_Src_Sel_E), .PC_Src_Sel_E(PC_Src_Sel_E),
        .RD_M(RD_M), .REG_W_En_M(REG_W_En_M), .MEM_Req_M(MEM_Req_M), .MEM_Ack(MEM_Ack),
        .RD_W(RD_W), .REG_W_En_W(REG_W_En_W),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
        .Forward_A_E(Forward_A_E), .Forward_B_E(Forward_B_E),
        .MEM_Err(MEM_Err), .Stall_Cycles(Stall_Cycles)
    );

    always #5 CLK = ~CLK;

    assign w_obs = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
                    Forward_A_E, Forward_B_E, MEM_Err};

    // stall = {F,D,E,M}, flush = {D,E,W}
    function automatic logic [11:0] mk(input logic [3:0] stall, input logic [2:0] flush,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic err);
        return {stall, flush, fa, fb, err};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
        Result_Src_Sel_E = 2'b00; PC_Src_Sel_E = 0; REG_W_En_M = 0; REG_W_En_W = 0;
        MEM_Req_M = 0; MEM_Ack = 0;
    endtask

    // Inputs are already applied; expectation is queued, then checked mid-cycle.
    task automatic cyc(input string tag, input logic [11:0] e);
        logic [11:0] x;
        sb.push_back(e);
        @(negedge CLK);
        x = sb.pop_front();
        check_eq(tag, 32'(w_obs), 32'(x));
        check_eq({tag, "_cnt"}, 32'(Stall_Cycles), 32'(exp_cnt));
        if (e[11] && exp_cnt != c_CNT_MAX) exp_cnt++;
        @(posedge CLK);
        #1;
    endtask

    task automatic async_reset_check(input string tag);
        #2 RST = 1'b1;
        #1;
        exp_cnt = 0;
        check_eq(tag, 32'(w_obs), 32'(mk(4'h0, 3'b111, 2'b00, 2'b00, 1'b0)));
        check_eq({tag, "_cnt"}, 32'(Stall_Cycles), 32'(0));
        @(posedge CLK);
        #1 RST = 1'b0;
        clr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        clr();
        RS1_E = 5'd3; RD_M = 5'd3; REG_W_En_M = 1'b1;
        cyc("reset", mk(4'h0, 3'b111, 2'b00, 2'b00, 1'b0));
        RST = 1'b0;
        clr();
        cyc("idle", mk(4'h0, 3'b000, 2'b00, 2'b00, 1'b0));

        Result_Src_Sel_E = 2'b01; RD_E = 5'd5; RS1_D = 5'd5;
        cyc("loaduse", mk(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0));
        clr();
        cyc("loaduse_rel", mk(4'h0, 3'b000, 2'b00, 2'b00, 1'b0));
        Result_Src_Sel_E = 2'b01; RD_E = 5'd0; RS1_D = 5'd0;
        cyc("loaduse_x0", mk(4'h0, 3'b000, 2'b00, 2'b00, 1'b0));
        clr();
        PC_Src_Sel_E = 1; Result_Src_Sel_E = 2'b01; RD_E = 5'd5; RS2_D = 5'd5;
        cyc("br_loaduse", mk(4'h0, 3'b110, 2'b00, 2'b00, 1'b0));

        clr();
        RD_M = 5'd7; RD_W = 5'd7; REG_W_En_M = 1; REG_W_En_W = 1; RS1_E = 5'd7; RS2_E = 5'd7;
        cyc("fwd_mem", mk(4'h0, 3'b000, 2'b10, 2'b10, 1'b0));
        REG_W_En_M = 0;
        cyc("fwd_wb", mk(4'h0, 3'b000, 2'b01, 2'b01, 1'b0));
        REG_W_En_M = 1; RD_M = 5'd0; RS2_E = 5'd0;
        cyc("fwd_x0", mk(4'h0, 3'b000, 2'b01, 2'b00, 1'b0));

        clr();
        MEM_Req_M = 1; MEM_Ack = 1;
        cyc("mem_zero_wait", mk(4'h0, 3'b000, 2'b00, 2'b00, 1'b0));
        MEM_Ack = 0; PC_Src_Sel_E = 1;
        for (int i = 0; i < 3; i++)
            cyc("mem_wait", mk(4'hF, 3'b001, 2'b00, 2'b00, 1'b0));
        MEM_Ack = 1;
        cyc("mem_release_br", mk(4'h0, 3'b110, 2'b00, 2'b00, 1'b0));
        clr();
        cyc("mem_idle", mk(4'h0, 3'b000, 2'b00, 2'b00, 1'b0));

        MEM_Req_M = 1;
        cyc("abort_wait", mk(4'hF, 3'b001, 2'b00, 2'b00, 1'b0));
        MEM_Req_M = 0;
        cyc("abort_drop", mk(4'h0, 3'b000, 2'b00, 2'b00, 1'b0));
        MEM_Req_M = 1; MEM_Ack = 1;
        cyc("abort_run", mk(4'h0, 3'b000, 2'b00, 2'b00, 1'b0));

        clr();
        Result_Src_Sel_E = 2'b01; RD_E = 5'd9; RS2_D = 5'd9;
        for (int i = 0; i < 20; i++)
            cyc("saturate", mk(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0));

        clr();
        MEM_Req_M = 1;
        for (int i = 0; i <= c_TO; i++)
            cyc("to_wait", mk(4'hF, 3'b001, 2'b00, 2'b00, 1'b0));
        PC_Src_Sel_E = 1;
        cyc("timeout", mk(4'hF, 3'b001, 2'b00, 2'b00, 1'b1));
        MEM_Req_M = 0; PC_Src_Sel_E = 0;
        cyc("timeout_noreq", mk(4'hF, 3'b001, 2'b00, 2'b00, 1'b1));
        MEM_Req_M = 1; MEM_Ack = 1;
        cyc("timeout_ack", mk(4'hF, 3'b001, 2'b00, 2'b00, 1'b1));
        async_reset_check("arst_timeout");

        MEM_Req_M = 1;
        for (int i = 0; i < 2; i++)
            cyc("arst_prewait", mk(4'hF, 3'b001, 2'b00, 2'b00, 1'b0));
        async_reset_check("arst_midwait");
        cyc("post_reset_idle", mk(4'h0, 3'b000, 2'b00, 2'b00, 1'b0));
        MEM_Req_M = 1;
        cyc("post_reset_wait", mk(4'hF, 3'b001, 2'b00, 2'b00, 1'b0));
        MEM_Ack = 1;
        cyc("post_reset_ack", mk(4'h0, 3'b000, 2'b00, 2'b00, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
